// File: rtl/atan_cordic.sv
// Iterative vectoring-mode CORDIC: rotates (x,y) onto the +x axis one micro-rotation
// per clock, accumulating atan2(y,x) in Q16 radians and leaving K*|v| in x.
module atan_cordic #(
  parameter int ITER = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] x_i,
  input  logic signed [31:0] y_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] angle_o,
  output logic signed [31:0] mag_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [31:0] PI   = 32'sd205887;
  localparam logic [4:0]         LAST = 5'(ITER - 1);

  // atan(2^-i) in unsigned Q16, one entry per micro-rotation.
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    logic signed [31:0] val;
    case (idx)
      5'd0:    val = 32'sh0000_c910;
      5'd1:    val = 32'sh0000_76b2;
      5'd2:    val = 32'sh0000_3eb7;
      5'd3:    val = 32'sh0000_1fd6;
      5'd4:    val = 32'sh0000_0ffb;
      5'd5:    val = 32'sh0000_07ff;
      5'd6:    val = 32'sh0000_0400;
      5'd7:    val = 32'sh0000_0200;
      5'd8:    val = 32'sh0000_0100;
      5'd9:    val = 32'sh0000_0080;
      5'd10:   val = 32'sh0000_0040;
      5'd11:   val = 32'sh0000_0020;
      5'd12:   val = 32'sh0000_0010;
      5'd13:   val = 32'sh0000_0008;
      5'd14:   val = 32'sh0000_0004;
      5'd15:   val = 32'sh0000_0002;
      default: val = 32'sh0000_0000;
    endcase
    return val;
  endfunction

  logic [1:0]         state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [4:0]         i_q, i_d;
  logic               zero_q, zero_d;
  logic signed [31:0] angle_q, angle_d;
  logic signed [31:0] mag_q, mag_d;

  logic signed [31:0] x_sh, y_sh, x_step, y_step, z_step;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign angle_o   = angle_q;
  assign mag_o     = mag_q;

  // One micro-rotation built from shifted copies of the old x and y.
  always_comb begin
    x_sh = x_q >>> i_q;
    y_sh = y_q >>> i_q;
    if (!y_q[31]) begin
      x_step = x_q + y_sh;
      y_step = y_q - x_sh;
      z_step = z_q + atan_lut(i_q);
    end else begin
      x_step = x_q - y_sh;
      y_step = y_q + x_sh;
      z_step = z_q - atan_lut(i_q);
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Left half-plane vectors are flipped by PI; y=0 with x<0 lands on +PI.
          if (!x_i[31]) begin
            x_d = x_i;
            y_d = y_i;
            z_d = '0;
          end else begin
            x_d = -x_i;
            y_d = -y_i;
            z_d = y_i[31] ? -PI : PI;
          end
          // The zero vector has no defined angle; the iteration would drift to +1.74 rad.
          zero_d  = (x_i == '0) && (y_i == '0);
          i_d     = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        x_d = x_step;
        y_d = y_step;
        z_d = z_step;
        i_d = i_q + 5'd1;
        if (i_q == LAST) begin
          angle_d = zero_q ? '0 : z_step;
          mag_d   = x_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

endmodule
